// File: rtl/fetch_pc_unit.sv
// IF-stage fetch sequencer: owns the PC, keeps one fetch outstanding at a time,
// and loads the IF/ID register. Redirects from ID squash wrong-path fetches.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] if_pc,
    output logic [15:0] if_instr,
    output logic        if_valid,
    output logic        flush
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic        discard;
    logic [15:0] pc;
    logic [15:0] buf_instr;
    logic        req_q;
    logic        accept;
    logic [15:0] tgt;

    // The request is a register so it stays low during reset and never
    // depends combinationally on an input.
    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign accept    = req_q && imem_ack;
    assign tgt       = branch_target & 16'hFFFE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ISSUE;
            discard   <= 1'b0;
            pc        <= RESET_PC & 16'hFFFE;
            buf_instr <= 16'h0000;
            req_q     <= 1'b0;
            if_pc     <= 16'h0000;
            if_instr  <= 16'h0000;
            if_valid  <= 1'b0;
            flush     <= 1'b0;
        end else begin
            flush <= branch_taken;
            req_q <= 1'b0;
            if (branch_taken) begin
                // Redirect wins over stall and normal fetch progress.
                pc       <= tgt;
                if_valid <= 1'b0;
                case (state)
                    S_ISSUE: begin
                        if (accept) begin
                            state   <= S_WAIT;
                            discard <= 1'b1;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            state   <= S_ISSUE;
                            discard <= 1'b0;
                            req_q   <= 1'b1;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_ISSUE;
                        req_q <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    S_ISSUE: begin
                        if (accept) begin
                            state <= S_WAIT;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (discard) begin
                                discard <= 1'b0;
                                state   <= S_ISSUE;
                                req_q   <= 1'b1;
                            end else if (!stall) begin
                                if_pc    <= pc;
                                if_instr <= imem_rdata;
                                if_valid <= 1'b1;
                                pc       <= pc + 16'd2;
                                state    <= S_ISSUE;
                                req_q    <= 1'b1;
                            end else begin
                                buf_instr <= imem_rdata;
                                state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            if_pc    <= pc;
                            if_instr <= buf_instr;
                            if_valid <= 1'b1;
                            pc       <= pc + 16'd2;
                            state    <= S_ISSUE;
                            req_q    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_ISSUE;
                        req_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a scoreboard queue of hand-computed
// {if_pc, if_instr} pairs checked by a monitor, plus direct control checks.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    logic [31:0] sb[$];

    fetch_pc_unit #(.RESET_PC(16'h0010)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .flush        (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for a request, check its address, accept it for one cycle.
    task automatic grant(input logic [15:0] exp_addr, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            step(1);
        end
        check1({name, "_req"}, got, 1'b1);
        check16({name, "_addr"}, imem_addr, exp_addr);
        imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
    endtask

    task automatic wait_req(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            step(1);
        end
        check1({name, "_req"}, got, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            step(1);
        end
        check16({name, "_pending"}, 16'(sb.size()), 16'd0);
    endtask

    // Instruction memory responder: rvalid arrives lat cycles after accept.
    initial begin
        logic        acc;
        logic [15:0] acc_addr;
        logic        pend;
        int          cnt;
        logic [15:0] paddr;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 16'h0000;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_ack;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = acc_addr;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = paddr ^ 16'hA5A5;
                        pend        = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every newly loaded IF/ID entry must match the scoreboard head.
    initial begin
        logic        prev_valid;
        logic [15:0] prev_pc;
        logic [15:0] prev_instr;
        logic [31:0] exp;
        prev_valid = 1'b0;
        prev_pc    = 16'h0000;
        prev_instr = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (if_valid && (!prev_valid || if_pc != prev_pc || if_instr != prev_instr)) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_instr: got pc %h instr %h expected none", if_pc, if_instr);
                    end else begin
                        exp = sb.pop_front();
                        check16("if_pc", if_pc, exp[31:16]);
                        check16("if_instr", if_instr, exp[15:0]);
                    end
                end
                prev_valid = if_valid;
                prev_pc    = if_pc;
                prev_instr = if_instr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        step(2);

        // Reset values
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", if_valid, 1'b0);
        check1("rst_flush", flush, 1'b0);
        check16("rst_addr", imem_addr, 16'h0010);
        check16("rst_if_pc", if_pc, 16'h0000);
        check16("rst_if_instr", if_instr, 16'h0000);
        rst_n = 1'b1;

        // Zero-wait sequential fetch
        sb.push_back({16'h0010, 16'hA5B5});
        grant(16'h0010, "seq0");
        sb.push_back({16'h0012, 16'hA5B7});
        grant(16'h0012, "seq1");
        sb.push_back({16'h0014, 16'hA5B1});
        grant(16'h0014, "seq2");
        drain("seq");
        check1("seq_valid", if_valid, 1'b1);

        // Slow memory: no request while waiting
        lat = 3;
        sb.push_back({16'h0016, 16'hA5B3});
        grant(16'h0016, "slow");
        for (int i = 0; i < 3; i++) begin
            check1("slow_req_low", imem_req, 1'b0);
            check16("slow_addr_hold", imem_addr, 16'h0016);
            step(1);
        end
        lat = 1;
        drain("slow");
        check16("slow_next_addr", imem_addr, 16'h0018);

        // Stall while data returns: word buffered, IF/ID held
        stall = 1'b1;
        sb.push_back({16'h0018, 16'hA5BD});
        grant(16'h0018, "stall");
        step(1);
        for (int i = 0; i < 3; i++) begin
            check16("stall_if_pc", if_pc, 16'h0016);
            check16("stall_if_instr", if_instr, 16'hA5B3);
            check1("stall_valid", if_valid, 1'b1);
            check1("stall_req_low", imem_req, 1'b0);
            step(1);
        end
        stall = 1'b0;
        step(1);
        check16("unstall_if_pc", if_pc, 16'h0018);
        drain("stall");

        // Redirect while waiting: returning word discarded
        lat = 3;
        grant(16'h001A, "rw");
        branch_taken  = 1'b1;
        branch_target = 16'h0101;
        step(1);
        branch_taken = 1'b0;
        check1("rw_flush", flush, 1'b1);
        check1("rw_valid", if_valid, 1'b0);
        check16("rw_addr", imem_addr, 16'h0100);
        check1("rw_req_low", imem_req, 1'b0);
        step(1);
        check1("rw_flush_end", flush, 1'b0);
        lat = 1;
        sb.push_back({16'h0100, 16'hA4A5});
        grant(16'h0100, "rw_tgt");
        drain("rw");

        // Redirect in ISSUE with the request accepted
        wait_req("ri_ack");
        imem_ack      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        step(1);
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        check1("ri_ack_flush", flush, 1'b1);
        check1("ri_ack_req_low", imem_req, 1'b0);
        check16("ri_ack_addr", imem_addr, 16'h0200);
        sb.push_back({16'h0200, 16'hA7A5});
        grant(16'h0200, "ri_ack_tgt");
        drain("ri_ack");

        // Redirect in ISSUE with the request not accepted
        wait_req("ri_nack");
        branch_taken  = 1'b1;
        branch_target = 16'h0300;
        step(1);
        branch_taken = 1'b0;
        check16("ri_nack_addr", imem_addr, 16'h0300);
        check1("ri_nack_req", imem_req, 1'b1);
        check1("ri_nack_flush", flush, 1'b1);
        sb.push_back({16'h0300, 16'hA6A5});
        grant(16'h0300, "ri_nack_tgt");
        check1("ri_nack_flush_end", flush, 1'b0);
        drain("ri_nack");

        // PC wrap from 0xFFFE, odd target bit ignored
        wait_req("wrap");
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step(1);
        branch_taken = 1'b0;
        check16("wrap_tgt_addr", imem_addr, 16'hFFFE);
        sb.push_back({16'hFFFE, 16'h5A5B});
        grant(16'hFFFE, "wrap_top");
        sb.push_back({16'h0000, 16'hA5A5});
        grant(16'h0000, "wrap_zero");
        drain("wrap");

        // Asynchronous reset mid-fetch
        lat = 3;
        grant(16'h0002, "arst");
        #3;
        rst_n = 1'b0;
        #1;
        check1("arst_valid", if_valid, 1'b0);
        check1("arst_req", imem_req, 1'b0);
        check1("arst_flush", flush, 1'b0);
        check16("arst_addr", imem_addr, 16'h0010);
        check16("arst_if_pc", if_pc, 16'h0000);
        check16("arst_if_instr", if_instr, 16'h0000);
        step(2);
        rst_n = 1'b1;
        lat   = 1;
        sb.push_back({16'h0010, 16'hA5B5});
        grant(16'h0010, "post_rst");
        drain("post_rst");
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

IF-stage fetch sequencer for the 16-bit pipeline. It owns the program counter and issues one instruction fetch at a time to instruction memory. It loads the IF/ID pipeline register and accepts the redirect (target + taken) from the ID-stage branch unit. A redirect squashes any wrong-path instruction, including a fetch already in flight.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- branch_taken  input  1  ID branch unit: redirect request this cycle
- branch_target  input  16  ID branch unit: redirect address; bit 0 ignored (forced 0)
- stall  input  1  hazard unit: hold IF/ID contents and PC advance
- imem_req  output  1  fetch request valid
- imem_addr  output  16  fetch address (current PC)
- imem_ack  input  1  memory accepts request this cycle (imem_req && imem_ack)
- imem_rvalid  input  1  read data valid; arrives ≥1 cycle after accept
- imem_rdata  input  16  instruction word
- if_pc  output  16  IF/ID register: PC of held instruction
- if_instr  output  16  IF/ID register: instruction
- if_valid  output  1  IF/ID register holds a real instruction
- flush  output  1  registered one-cycle pulse after an accepted redirect

## Operation
- Reset values: pc=RESET_PC, state=ISSUE, discard=0, buffer empty, if_pc=0, if_instr=0, if_valid=0, flush=0, imem_req=0 while rst_n low.
- At most one outstanding fetch. imem_addr is always pc.
- States:
  - ISSUE: imem_req=1. On imem_ack, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - discard=1: drop the data, clear discard, go to ISSUE.
    - else stall=0: load IF/ID {pc, rdata, valid=1}, pc+=2, go to ISSUE.
    - else: capture rdata in a 1-entry buffer, go to HOLD.
  - HOLD: imem_req=0. When stall=0, load IF/ID from the buffer, pc+=2, go to ISSUE.
- Stall: if_pc, if_instr and if_valid hold while stall=1. When IF/ID is not written, if_valid is unchanged.
- Redirect (branch_taken=1) has priority over stall and normal fetch. In the same cycle:
  - pc <= {branch_target[15:1], 0}
  - if_valid <= 0
  - buffer cleared
  - flush <= 1 for exactly one cycle
- Redirect by state:
  - ISSUE with imem_ack=1: the accepted request is wrong-path; go to WAIT with discard=1.
  - ISSUE with imem_ack=0: the request is withdrawn; stay in ISSUE; the new address is presented next cycle. The memory tolerates an address change on an unaccepted request.
  - WAIT: set discard=1 (rvalid in the same cycle is also discarded; next state ISSUE, discard=0).
  - HOLD: drop the buffer, go to ISSUE.
- Arithmetic: pc+2 modulo 2^16 (0xFFFE → 0x0000); no carry out.
- Reset asserted mid-fetch: all state returns to reset values immediately. Any later imem_rvalid for a pre-reset request is the memory's responsibility; the memory returns none.

## Timing
- Zero-wait memory (ack in the issue cycle, rvalid the next cycle): one instruction every 2 cycles.
- Instruction returned at edge N appears on if_* after edge N (registered).
- Redirect at edge N:
  - if_valid=0 and flush=1 during cycle N+1.
  - imem_addr = target from cycle N+1, in ISSUE or WAIT.
- flush is never high for two consecutive cycles unless branch_taken is high in two consecutive cycles.
- Every output is a register or a pure decode of state; there is no combinational path from any input to any output.

## Test plan
- Reset with RESET_PC=0x0010, zero-wait memory returning addr^16'hA5A5 → if_pc sequence 0x0010, 0x0012, 0x0014, if_valid=1, imem_req low during reset.
- rvalid delayed 3 cycles → imem_req low in WAIT, no second request; if_instr matches and pc advances by exactly 2.
- stall=1 for 4 cycles while data returns → HOLD entered, if_* unchanged during stall; buffered word loads on the cycle stall drops.
- branch_taken with target 0x0101 while in WAIT → flush pulse of 1 cycle, if_valid=0, returning word discarded, next imem_addr=0x0100.
- Redirect in ISSUE with imem_ack=1 → that response dropped; redirect with imem_ack=0 → imem_addr switches to target next cycle.
- pc=0xFFFE fetch → next imem_addr=0x0000; rst_n pulled low in WAIT → outputs return to reset values asynchronously.
